ref_bank_loader: RTL and testbench
==================================

REF_BANK_LOADER -- requirements
Module: ref_bank_loader

Interface
REQ-001 Parameter NUM_BANKS, default 4: number of downstream reference banks fed by this block.
REQ-002 Parameter BURST_LEN, default 24: 64-bit words written into one bank before rotating to the next.
REQ-003 Parameter SEGS, default 4: bursts per bank before that bank's write counter wraps (bank depth 96 = SEGS*BURST_LEN).
REQ-004 clk  input  1  clock; all logic rising-edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  single-cycle pulse; begins a load of burst_total bursts; ignored unless IDLE.
REQ-007 burst_total  input  8  number of bursts in this load, sampled on accepted start; value 0 treated as 1.
REQ-008 in_valid  input  1  upstream word valid.
REQ-009 in_data  input  64  upstream word, 8 pixels x 8 bit.
REQ-010 in_ready  output  1  block accepts in_data this cycle; a transfer occurs when in_valid && in_ready.
REQ-011 seg_release  input  1  single-cycle pulse from consumer; frees one occupied bank segment.
REQ-012 beg_en  output  1  bank write strobe, registered.
REQ-013 bank_sel  output  NUM_BANKS  one-hot bank select, registered, aligned with beg_en.
REQ-014 ref_out  output  64  write data to banks, registered, aligned with beg_en.
REQ-015 seg_done  output  1  one-cycle pulse on the cycle the last word of a burst appears on ref_out.
REQ-016 seg_bank  output  log2(NUM_BANKS)  bank index of the burst flagged by seg_done.
REQ-017 seg_idx  output  log2(SEGS)  segment index within that bank of the flagged burst.
REQ-018 occupancy  output  5  number of written, unreleased segments (0..NUM_BANKS*SEGS).
REQ-019 busy  output  1  high in every state except IDLE.
REQ-020 load_done  output  1  one-cycle pulse when the final burst of a load has been written.
REQ-021 rel_err  output  1  sticky; set on seg_release while occupancy = 0.

Function
REQ-022 FSM states: IDLE, XFER, STALL; transitions are evaluated on clk edges only.
REQ-023 IDLE -> XFER on start; burst counter, word counter cleared; bank pointer and seg pointer persist across loads.
REQ-024 XFER: in_ready = 1; each transfer registers in_data to ref_out with beg_en = 1 and bank_sel = one-hot(bank pointer), 1-cycle latency.
REQ-025 Cycles without a transfer drive beg_en = 0 and bank_sel = 0; ref_out holds its last value.
REQ-026 Word counter 0..BURST_LEN-1; on the transfer at count BURST_LEN-1 the burst completes: counter -> 0, bank pointer +1 modulo NUM_BANKS.
REQ-027 Seg pointer increments modulo SEGS when the bank pointer wraps from NUM_BANKS-1 to 0, matching each bank's own write-counter wrap.
REQ-028 On burst completion, occupancy +1, and seg_done, seg_bank, seg_idx are valid together with the last beg_en of the burst.
REQ-029 seg_release decrements occupancy by 1; simultaneous completion and release leaves occupancy unchanged.
REQ-030 seg_release at occupancy 0 leaves occupancy 0 and sets rel_err.
REQ-031 A burst is started only if occupancy < NUM_BANKS*SEGS (counting a completion in the same cycle); otherwise XFER -> STALL at the burst boundary.
REQ-032 STALL: in_ready = 0; on seg_release -> XFER, with in_ready = 1 from the next cycle.
REQ-033 Stalls occur only at burst boundaries; a burst in progress is never interrupted by backpressure.
REQ-034 On completion of burst number burst_total: load_done pulses on the same cycle as seg_done, FSM -> IDLE, in_ready = 0.
REQ-035 start while busy is ignored.

Reset
REQ-036 rst_n low asynchronously forces IDLE and clears all counters and pointers, with occupancy = 0 and rel_err = 0.
REQ-037 During reset, in_ready, beg_en, seg_done, load_done and busy = 0, bank_sel = 0, and ref_out, seg_bank, seg_idx = 0.
REQ-038 Reset mid-burst discards the partial burst; no seg_done is issued for it.

Verification
REQ-039 start, burst_total = 4, continuous valid: 96 transfers -> bank_sel 0001, 0010, 0100, 1000, 24 beg_en each; seg_idx = 0 for all; load_done one cycle after word 96 is accepted; occupancy = 4.
REQ-040 Load 16 bursts, no release -> occupancy = 16, load_done; a second load of 1 burst enters STALL with in_ready = 0; one seg_release -> resumes on bank 0, seg_idx 0.
REQ-041 in_valid toggling 1010... -> beg_en follows accepted words only, and 24 beg_en per bank_sel value.
REQ-042 seg_release in the same cycle as a burst completion at occupancy 15 -> occupancy stays 15, and no stall.
REQ-043 seg_release with occupancy 0 -> rel_err = 1 and held until reset, with occupancy = 0.
REQ-044 rst_n asserted after word 10 of a burst -> all outputs 0 immediately; a fresh start writes bank 0, seg_idx 0.

Source files
------------

// File: rtl/ref_bank_loader.sv
// ref_bank_loader: streams 64-bit pixel words from an upstream source into a
// rotating set of reference banks, one BURST_LEN-word burst per bank, and
// tracks how many written bank segments the consumer has not yet released.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start, burst_total      begin a load of burst_total bursts (0 means 1)
//   in_valid, in_data       upstream word; in_ready accepts it
//   seg_release             consumer frees one occupied segment
//   beg_en, bank_sel        registered bank write strobe and one-hot select
//   ref_out                 registered bank write data
//   seg_done, seg_bank,     pulse and location of a completed burst
//   seg_idx
//   occupancy               written, unreleased segments
//   busy, load_done         activity flag and end-of-load pulse
//   rel_err                 sticky release-underflow flag
module ref_bank_loader #(
  parameter int unsigned NUM_BANKS = 4,
  parameter int unsigned BURST_LEN = 24,
  parameter int unsigned SEGS      = 4,
  localparam int unsigned BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int unsigned SEG_W    = (SEGS > 1) ? $clog2(SEGS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [7:0]           burst_total,
  input  logic                 in_valid,
  input  logic [63:0]          in_data,
  output logic                 in_ready,
  input  logic                 seg_release,
  output logic                 beg_en,
  output logic [NUM_BANKS-1:0] bank_sel,
  output logic [63:0]          ref_out,
  output logic                 seg_done,
  output logic [BANK_W-1:0]    seg_bank,
  output logic [SEG_W-1:0]     seg_idx,
  output logic [4:0]           occupancy,
  output logic                 busy,
  output logic                 load_done,
  output logic                 rel_err
);

  localparam int unsigned WORD_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned OCC_W  = 5;
  localparam int unsigned CAP    = NUM_BANKS * SEGS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t              state;
  logic [WORD_W-1:0]   word_cnt;
  logic [7:0]          burst_cnt;
  logic [7:0]          burst_goal;
  logic [BANK_W-1:0]   bank_ptr;
  logic [SEG_W-1:0]    seg_ptr;

  logic                xfer_c;
  logic                last_word_c;
  logic                complete_c;
  logic                last_burst_c;
  logic                rel_bad_c;
  logic                full_nxt_c;
  logic [OCC_W-1:0]    occ_nxt_c;

  // in_ready is a registered copy of "state is XFER", so it doubles as the
  // handshake qualifier.
  assign xfer_c       = in_valid && in_ready;
  assign last_word_c  = (word_cnt == WORD_W'(BURST_LEN - 1));
  assign complete_c   = xfer_c && last_word_c;
  assign last_burst_c = (burst_cnt == (burst_goal - 8'd1));
  // A release with nothing occupied is an error unless a burst completes
  // in the same cycle, in which case the two cancel.
  assign rel_bad_c    = seg_release && (occupancy == '0) && !complete_c;
  assign full_nxt_c   = (occ_nxt_c >= OCC_W'(CAP));

  // Next occupancy: completion and release cancel when simultaneous.
  always_comb begin
    occ_nxt_c = occupancy;
    if (complete_c && !seg_release) begin
      occ_nxt_c = occupancy + OCC_W'(1);
    end else if (!complete_c && seg_release && (occupancy != '0)) begin
      occ_nxt_c = occupancy - OCC_W'(1);
    end
  end

  // Control FSM, counters, pointers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_cnt   <= '0;
      burst_cnt  <= '0;
      burst_goal <= 8'd1;
      bank_ptr   <= '0;
      seg_ptr    <= '0;
      in_ready   <= 1'b0;
      beg_en     <= 1'b0;
      bank_sel   <= '0;
      ref_out    <= '0;
      seg_done   <= 1'b0;
      seg_bank   <= '0;
      seg_idx    <= '0;
      occupancy  <= '0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      rel_err    <= 1'b0;
    end else begin
      beg_en    <= 1'b0;
      bank_sel  <= '0;
      seg_done  <= 1'b0;
      load_done <= 1'b0;
      occupancy <= occ_nxt_c;
      if (rel_bad_c) begin
        rel_err <= 1'b1;
      end

      // Datapath: one registered bank write per accepted word.
      if (xfer_c) begin
        beg_en   <= 1'b1;
        bank_sel <= NUM_BANKS'(1) << bank_ptr;
        ref_out  <= in_data;
        if (last_word_c) begin
          word_cnt  <= '0;
          burst_cnt <= burst_cnt + 8'd1;
          seg_done  <= 1'b1;
          seg_bank  <= bank_ptr;
          seg_idx   <= seg_ptr;
          // Segment advances each time the bank rotation wraps.
          if (bank_ptr == BANK_W'(NUM_BANKS - 1)) begin
            bank_ptr <= '0;
            seg_ptr  <= (seg_ptr == SEG_W'(SEGS - 1)) ? '0 : seg_ptr + SEG_W'(1);
          end else begin
            bank_ptr <= bank_ptr + BANK_W'(1);
          end
        end else begin
          word_cnt <= word_cnt + WORD_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            word_cnt   <= '0;
            burst_cnt  <= '0;
            burst_goal <= (burst_total == 8'd0) ? 8'd1 : burst_total;
            busy       <= 1'b1;
            if (full_nxt_c) begin
              state    <= STALL;
              in_ready <= 1'b0;
            end else begin
              state    <= XFER;
              in_ready <= 1'b1;
            end
          end
        end
        XFER: begin
          // Decisions happen only at burst boundaries.
          if (complete_c) begin
            if (last_burst_c) begin
              load_done <= 1'b1;
              state     <= IDLE;
              in_ready  <= 1'b0;
              busy      <= 1'b0;
            end else if (full_nxt_c) begin
              state    <= STALL;
              in_ready <= 1'b0;
            end
          end
        end
        STALL: begin
          if (seg_release) begin
            state    <= XFER;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ref_bank_loader.sv
// Scoreboard bench for ref_bank_loader: the stimulus side pushes the expected
// bank write for every accepted word; a monitor pops and compares on each
// beg_en. Status outputs are checked against hand-computed values.
module tb_ref_bank_loader;

  localparam int NB  = 4;
  localparam int BL  = 24;
  localparam int SG  = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  burst_total;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        seg_release;
  logic        beg_en;
  logic [3:0]  bank_sel;
  logic [63:0] ref_out;
  logic        seg_done;
  logic [1:0]  seg_bank;
  logic [1:0]  seg_idx;
  logic [4:0]  occupancy;
  logic        busy;
  logic        load_done;
  logic        rel_err;

  ref_bank_loader #(.NUM_BANKS(NB), .BURST_LEN(BL), .SEGS(SG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_total(burst_total),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .seg_release(seg_release), .beg_en(beg_en), .bank_sel(bank_sel),
    .ref_out(ref_out), .seg_done(seg_done), .seg_bank(seg_bank),
    .seg_idx(seg_idx), .occupancy(occupancy), .busy(busy),
    .load_done(load_done), .rel_err(rel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic [63:0] data;
    logic        sd;
    logic [1:0]  sb;
    logic [1:0]  si;
    logic        ld;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of where the next accepted word lands.
  int m_bank = 0, m_seg = 0, m_word = 0, m_burst = 0, m_total = 1;
  int load_tag = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every bank write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n) begin
      if (beg_en) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_write: got sel=%b data=%h, no write expected", bank_sel, ref_out);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bank_sel !== e.sel || ref_out !== e.data || seg_done !== e.sd ||
              load_done !== e.ld || (e.sd && (seg_bank !== e.sb || seg_idx !== e.si))) begin
            n_fail++;
            $display("FAIL write: got sel=%b data=%h sd=%b ld=%b sb=%0d si=%0d expected sel=%b data=%h sd=%b ld=%b sb=%0d si=%0d",
                     bank_sel, ref_out, seg_done, load_done, seg_bank, seg_idx,
                     e.sel, e.data, e.sd, e.ld, e.sb, e.si);
          end
        end
      end else if (seg_done || load_done || bank_sel != 4'd0) begin
        n_tests++;
        n_fail++;
        $display("FAIL idle_strobe: got sd=%b ld=%b sel=%b expected all 0", seg_done, load_done, bank_sel);
      end
    end
  end

  task automatic start_load(input int t);
    @(negedge clk);
    start = 1'b1;
    burst_total = 8'(t);
    m_total = (t == 0) ? 1 : t;
    m_word = 0;
    m_burst = 0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic release_seg();
    @(negedge clk);
    seg_release = 1'b1;
    @(negedge clk);
    seg_release = 1'b0;
  endtask

  // Offer n words; toggle alternates in_valid; a release pulse rides on
  // word rel_at. Returns the number of cycles used.
  task automatic drive(input int n, input bit toggle, input int rel_at, output int cycles);
    int sent;
    bit ph;
    exp_t e;
    sent = 0;
    cycles = 0;
    ph = 1'b1;
    load_tag++;
    while (sent < n && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      seg_release = 1'b0;
      in_valid = toggle ? ph : 1'b1;
      ph = ~ph;
      in_data = {32'hC0DE_0000 | 32'(load_tag), 32'h5A5A_0000 ^ 32'(sent)};
      if (in_valid && in_ready) begin
        e.sel  = 4'(1) << m_bank;
        e.data = in_data;
        e.sd   = (m_word == BL - 1);
        e.sb   = 2'(m_bank);
        e.si   = 2'(m_seg);
        e.ld   = e.sd && (m_burst == m_total - 1);
        q.push_back(e);
        if (sent == rel_at) seg_release = 1'b1;
        sent++;
        if (m_word == BL - 1) begin
          m_word = 0;
          m_burst++;
          if (m_bank == NB - 1) begin
            m_bank = 0;
            m_seg = (m_seg + 1) % SG;
          end else begin
            m_bank++;
          end
        end else begin
          m_word++;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    seg_release = 1'b0;
    if (sent < n) begin
      n_tests++;
      n_fail++;
      $display("FAIL drive_timeout: got %0d words accepted expected %0d", sent, n);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
    chk({tag, "_beg_en"},    64'(beg_en),    64'd0);
    chk({tag, "_bank_sel"},  64'(bank_sel),  64'd0);
    chk({tag, "_ref_out"},   ref_out,        64'd0);
    chk({tag, "_seg_done"},  64'(seg_done),  64'd0);
    chk({tag, "_load_done"}, 64'(load_done), 64'd0);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    chk({tag, "_rel_err"},   64'(rel_err),   64'd0);
    chk({tag, "_seg_bank"},  64'(seg_bank),  64'd0);
    chk({tag, "_seg_idx"},   64'(seg_idx),   64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n = 1'b0;
    start = 1'b0;
    burst_total = 8'd0;
    in_valid = 1'b0;
    in_data = 64'd0;
    seg_release = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Four bursts, continuous valid: one burst per bank, segment 0.
    start_load(4);
    drive(96, 1'b0, -1, cyc);
    @(negedge clk);
    chk("a_cycles", 64'(cyc), 64'd96);
    chk("a_occupancy", 64'(occupancy), 64'd4);
    chk("a_busy", 64'(busy), 64'd0);
    chk("a_in_ready", 64'(in_ready), 64'd0);
    repeat (4) release_seg();
    chk("a_drain_occ", 64'(occupancy), 64'd0);

    // Release with nothing occupied.
    release_seg();
    @(negedge clk);
    chk("relerr_set", 64'(rel_err), 64'd1);
    chk("relerr_occ", 64'(occupancy), 64'd0);

    // Toggling valid: segment pointer persists (now 1).
    start_load(4);
    drive(96, 1'b1, -1, cyc);
    @(negedge clk);
    chk("c_cycles", 64'(cyc), 64'd191);
    chk("c_occupancy", 64'(occupancy), 64'd4);
    repeat (4) release_seg();
    chk("c_drain_occ", 64'(occupancy), 64'd0);
    chk("relerr_held", 64'(rel_err), 64'd1);

    // Reset after word 10 of a burst.
    start_load(2);
    drive(10, 1'b0, -1, cyc);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    chk("midrst_queue", 64'(q.size()), 64'd0);
    m_bank = 0;
    m_seg = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Fill all 16 segments; first burst lands on bank 0 segment 0.
    start_load(16);
    drive(384, 1'b0, -1, cyc);
    @(negedge clk);
    chk("e_occupancy", 64'(occupancy), 64'd16);
    chk("e_busy", 64'(busy), 64'd0);

    // Next load must wait for a release.
    start_load(1);
    repeat (3) @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_busy", 64'(busy), 64'd1);
    release_seg();
    chk("resume_in_ready", 64'(in_ready), 64'd1);
    chk("resume_occ", 64'(occupancy), 64'd15);
    drive(24, 1'b0, -1, cyc);
    @(negedge clk);
    chk("resume_final_occ", 64'(occupancy), 64'd16);

    // Release coincident with a completion at occupancy 15: no stall.
    release_seg();
    chk("f_start_occ", 64'(occupancy), 64'd15);
    start_load(2);
    drive(48, 1'b0, 23, cyc);
    @(negedge clk);
    chk("f_cycles", 64'(cyc), 64'd48);
    chk("f_occupancy", 64'(occupancy), 64'd16);
    chk("f_busy", 64'(busy), 64'd0);

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
